// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 write-only slave feeding five 8-bit control registers.
// All SPI pins are resynchronised into clk and decoded with edge detectors.
module spi_reg_bank #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_pulse,
    output logic       err_pulse
);
    localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_copi_sync, r_ncs_sync, r_flush;
    logic                   r_sclk_hist, r_copi_hist, r_ncs_hist, r_armed;
    logic [15:0]            r_shift;
    logic [4:0]             r_cnt;
    logic                   w_sclk_s, w_ncs_s, w_sclk_rise, w_ncs_rise, w_ncs_fall;
    logic [6:0]             w_addr;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_hist;
    assign w_ncs_fall  = ~w_ncs_s & r_ncs_hist;
    assign w_addr      = r_shift[14:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync     <= '0;
            r_copi_sync     <= '0;
            r_ncs_sync      <= '1;
            r_sclk_hist     <= 1'b0;
            r_copi_hist     <= 1'b0;
            r_ncs_hist      <= 1'b1;
            r_flush         <= '0;
            r_armed         <= 1'b0;
            r_shift         <= '0;
            r_cnt           <= '0;
            wr_pulse        <= 1'b0;
            err_pulse       <= 1'b0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_sclk_hist <= w_sclk_s;
            r_copi_hist <= r_copi_sync[SYNC_STAGES-1];
            r_ncs_hist  <= w_ncs_s;
            r_flush     <= {r_flush[SYNC_STAGES-2:0], 1'b1};
            wr_pulse    <= 1'b0;
            err_pulse   <= 1'b0;
            // Arm only once a genuine (post-reset) ncs-high sample has reached the chain end
            if (r_flush[SYNC_STAGES-1] && w_ncs_s)
                r_armed <= 1'b1;
            if (r_armed) begin
                if (w_ncs_fall)
                    r_cnt <= '0;
                else if (!w_ncs_s && w_sclk_rise) begin
                    r_shift <= {r_shift[14:0], r_copi_hist};
                    r_cnt   <= (r_cnt == 5'd17) ? r_cnt : r_cnt + 5'd1;
                end
                if (w_ncs_rise) begin
                    if (r_cnt != 5'd16 || !r_shift[15])
                        err_pulse <= 1'b1;
                    else if (w_addr <= MAX_A) begin
                        wr_pulse <= 1'b1;
                        case (w_addr)
                            7'd0:    en_reg_out_7_0  <= r_shift[7:0];
                            7'd1:    en_reg_out_15_8 <= r_shift[7:0];
                            7'd2:    en_reg_pwm_7_0  <= r_shift[7:0];
                            7'd3:    en_reg_pwm_15_8 <= r_shift[7:0];
                            7'd4:    pwm_duty_cycle  <= r_shift[7:0];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end
endmodule
